// File: rtl/regfile_cmd_sequencer.sv
// regfile_cmd_sequencer
//   Front-end controller for the register-file command bus. Accepts one
//   register micro-op per valid/ready handshake and expands it into an ordered
//   sequence of command codes on the shared bus. The register selects and the
//   ALU write-select are captured at acceptance and held until the next op.
//
// Optional feature (build macro SEQ_SKIP_LATCHSEL_EN):
//   When defined, the LATCHSEL step is skipped if selects have already been
//   latched once and the new op's sel_a/b/c equal the last latched selects.
//   When undefined, LATCHSEL is always issued for READ_AB, ALU_EXEC and WRITE_C.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready micro-op handshake
//   req_op              0=READ_AB 1=ALU_EXEC 2=WRITE_C 3=READ_F
//   req_sel_a/b/c       register selects of the request
//   req_wsel            ALU write-select of the request
//   stall               bus stall; freezes the sequence and forces COM_NOP
//   cmd                 command code driven onto the regfile bus
//   sel_a/b/c           latched selects
//   alu_wsel            latched ALU write-select
//   busy                op in flight
//   done                one-cycle pulse with an op's final command
//   state_dbg           {selects-latched flag, FSM state} for observation
//
// Handshake: a request is accepted on a rising edge where req_valid and
//   req_ready are both 1. req_ready is 1 only while idle; once it drops the
//   request fields are ignored until req_ready returns to 1.
module regfile_cmd_sequencer #(
  parameter int INDEX_WIDTH = 3,
  parameter int CMD_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [INDEX_WIDTH-1:0] req_sel_a,
  input  logic [INDEX_WIDTH-1:0] req_sel_b,
  input  logic [INDEX_WIDTH-1:0] req_sel_c,
  input  logic [1:0]             req_wsel,
  input  logic                   stall,
  output logic [CMD_WIDTH-1:0]   cmd,
  output logic [INDEX_WIDTH-1:0] sel_a,
  output logic [INDEX_WIDTH-1:0] sel_b,
  output logic [INDEX_WIDTH-1:0] sel_c,
  output logic [1:0]             alu_wsel,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             state_dbg
);

  localparam logic [CMD_WIDTH-1:0] COM_NOP      = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] COM_READA    = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] COM_READB    = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] COM_LATCHC   = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] COM_LATCHSEL = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] COM_READF    = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] COM_ALU_WE   = CMD_WIDTH'(6);

  localparam logic [1:0] OP_READ_AB  = 2'd0;
  localparam logic [1:0] OP_ALU_EXEC = 2'd1;
  localparam logic [1:0] OP_WRITE_C  = 2'd2;
  localparam logic [1:0] OP_READ_F   = 2'd3;

  localparam logic [1:0] WSEL_NONE = 2'd0;
  localparam logic [1:0] WSEL_REGC = 2'd1;
  localparam logic [1:0] WSEL_REGF = 2'd2;

  // Each non-IDLE state names the step that is pending issue on the bus.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LSEL = 3'd1,
    S_RDA  = 3'd2,
    S_RDB  = 3'd3,
    S_AWE  = 3'd4,
    S_LC   = 3'd5,
    S_RDF  = 3'd6
  } state_t;

  state_t     state;
  logic [1:0] op_q;
  logic       awe_q;
  logic       flag_q;

`ifdef SEQ_SKIP_LATCHSEL_EN
  logic [INDEX_WIDTH-1:0] lat_a, lat_b, lat_c;
  logic [INDEX_WIDTH-1:0] cur_a, cur_b, cur_c_lat;
`endif

  logic                   accept;
  logic                   active;
  logic                   wsel_ok;
  logic                   skip;
  logic [1:0]             cur_op;
  logic                   cur_awe;
  logic [INDEX_WIDTH-1:0] cur_c;
  state_t                 first_step;
  state_t                 cur_step;
  state_t                 next_step;
  logic [CMD_WIDTH-1:0]   step_cmd;

  always_comb begin
    accept  = req_valid && req_ready;
    wsel_ok = (req_op == OP_ALU_EXEC) &&
              ((req_wsel == WSEL_REGC) || (req_wsel == WSEL_REGF));
    // On the accept edge the step is issued from the request itself,
    // afterwards from the captured copy.
    cur_op  = accept ? req_op    : op_q;
    cur_awe = accept ? wsel_ok   : awe_q;
    cur_c   = accept ? req_sel_c : sel_c;

    skip = 1'b0;
`ifdef SEQ_SKIP_LATCHSEL_EN
    cur_a     = accept ? req_sel_a : sel_a;
    cur_b     = accept ? req_sel_b : sel_b;
    cur_c_lat = cur_c;
    skip = flag_q && (req_sel_a == lat_a) && (req_sel_b == lat_b) &&
           (req_sel_c == lat_c);
`endif

    if (req_op == OP_READ_F)       first_step = S_RDF;
    else if (!skip)                first_step = S_LSEL;
    else if (req_op == OP_WRITE_C) first_step = S_LC;
    else                           first_step = S_RDA;

    cur_step = (state == S_IDLE) ? first_step : state;
    active   = accept || (state != S_IDLE);

    step_cmd  = COM_NOP;
    next_step = S_IDLE;
    case (cur_step)
      S_LSEL: begin
        step_cmd  = COM_LATCHSEL;
        next_step = (cur_op == OP_WRITE_C) ? S_LC : S_RDA;
      end
      S_RDA: begin
        step_cmd  = COM_READA;
        next_step = S_RDB;
      end
      S_RDB: begin
        step_cmd  = COM_READB;
        next_step = cur_awe ? S_AWE : S_IDLE;
      end
      S_AWE:   step_cmd = COM_ALU_WE;
      // Writing the zero register is suppressed but still occupies the step.
      S_LC:    step_cmd = (cur_c == '0) ? COM_NOP : COM_LATCHC;
      S_RDF:   step_cmd = COM_READF;
      default: step_cmd = COM_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_READ_AB;
      awe_q     <= 1'b0;
      flag_q    <= 1'b0;
      cmd       <= COM_NOP;
      sel_a     <= '0;
      sel_b     <= '0;
      sel_c     <= '0;
      alu_wsel  <= WSEL_NONE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_SKIP_LATCHSEL_EN
      lat_a     <= '0;
      lat_b     <= '0;
      lat_c     <= '0;
`endif
    end else begin
      done <= 1'b0;
      cmd  <= COM_NOP;

      if (accept) begin
        op_q      <= req_op;
        awe_q     <= wsel_ok;
        sel_a     <= req_sel_a;
        sel_b     <= req_sel_b;
        sel_c     <= req_sel_c;
        alu_wsel  <= wsel_ok ? req_wsel : WSEL_NONE;
        req_ready <= 1'b0;
        busy      <= 1'b1;
      end else if (state == S_IDLE) begin
        // Reached one cycle after the final command.
        req_ready <= 1'b1;
        busy      <= 1'b0;
      end

      if (active) begin
        if (stall) begin
          state <= cur_step;
        end else begin
          cmd   <= step_cmd;
          state <= next_step;
          done  <= (next_step == S_IDLE);
          if (cur_step == S_LSEL) begin
            flag_q <= 1'b1;
`ifdef SEQ_SKIP_LATCHSEL_EN
            lat_a  <= cur_a;
            lat_b  <= cur_b;
            lat_c  <= cur_c_lat;
`endif
          end
        end
      end
    end
  end

  assign state_dbg = {flag_q, state};

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Testbench for regfile_cmd_sequencer: directed scenarios plus randomized
// traffic, compared each cycle against a queue-based command model.
module tb_regfile_cmd_sequencer;

`ifdef SEQ_SKIP_LATCHSEL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [2:0] req_sel_a = 3'd0, req_sel_b = 3'd0, req_sel_c = 3'd0;
  logic [1:0] req_wsel = 2'd0;
  logic       stall = 1'b0;
  logic       req_ready, busy, done;
  logic [3:0] cmd;
  logic [2:0] sel_a, sel_b, sel_c;
  logic [1:0] alu_wsel;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;

  regfile_cmd_sequencer #(.INDEX_WIDTH(3), .CMD_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sel_a(req_sel_a), .req_sel_b(req_sel_b),
    .req_sel_c(req_sel_c), .req_wsel(req_wsel), .stall(stall), .cmd(cmd),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .alu_wsel(alu_wsel),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Accepted ops are expanded into their full command list up front; one
  // command leaves the queue per unstalled cycle.
  logic [3:0] exp_q[$];
  logic       m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
  logic [3:0] m_cmd = 4'd0;
  logic [2:0] m_sel_a = 3'd0, m_sel_b = 3'd0, m_sel_c = 3'd0;
  logic [1:0] m_wsel = 2'd0;
  logic       m_flag = 1'b0;
  logic [2:0] m_lat_a = 3'd0, m_lat_b = 3'd0, m_lat_c = 3'd0;
  logic       m_accept, m_idle, m_ok, m_lsel;
  logic [3:0] m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_cmd = 4'd0;
      m_sel_a = 3'd0; m_sel_b = 3'd0; m_sel_c = 3'd0; m_wsel = 2'd0;
      m_flag = 1'b0; m_lat_a = 3'd0; m_lat_b = 3'd0; m_lat_c = 3'd0;
    end else begin
      m_accept = req_valid && m_ready;
      m_idle   = (exp_q.size() == 0);
      m_done   = 1'b0;
      m_cmd    = 4'd0;
      if (m_accept) begin
        m_sel_a = req_sel_a; m_sel_b = req_sel_b; m_sel_c = req_sel_c;
        m_ok    = (req_op == 2'd1) && (req_wsel == 2'd1 || req_wsel == 2'd2);
        m_wsel  = m_ok ? req_wsel : 2'd0;
        m_lsel  = !(SKIP && m_flag && req_sel_a == m_lat_a &&
                    req_sel_b == m_lat_b && req_sel_c == m_lat_c);
        case (req_op)
          2'd0, 2'd1: begin
            if (m_lsel) exp_q.push_back(4'd4);
            exp_q.push_back(4'd1);
            exp_q.push_back(4'd2);
            if (m_ok) exp_q.push_back(4'd6);
          end
          2'd2: begin
            if (m_lsel) exp_q.push_back(4'd4);
            exp_q.push_back((req_sel_c == 3'd0) ? 4'd0 : 4'd3);
          end
          default: exp_q.push_back(4'd5);
        endcase
        m_ready = 1'b0;
        m_busy  = 1'b1;
      end else if (m_idle) begin
        m_ready = 1'b1;
        m_busy  = 1'b0;
      end
      if (exp_q.size() > 0 && !stall) begin
        m_c   = exp_q.pop_front();
        m_cmd = m_c;
        if (m_c == 4'd4) begin
          m_flag = 1'b1;
          m_lat_a = m_sel_a; m_lat_b = m_sel_b; m_lat_c = m_sel_c;
        end
        if (exp_q.size() == 0) m_done = 1'b1;
      end
    end
  end

  wire [17:0] dut_vec = {req_ready, busy, done, cmd, sel_a, sel_b, sel_c, alu_wsel};
  wire [17:0] m_vec   = {m_ready, m_busy, m_done, m_cmd, m_sel_a, m_sel_b, m_sel_c, m_wsel};

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] c, input logic [1:0] w);
    req_valid = 1'b1; req_op = op;
    req_sel_a = a; req_sel_b = b; req_sel_c = c; req_wsel = w;
    step();
    req_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({req_ready, busy, done, cmd, sel_a, sel_b, sel_c, alu_wsel, state_dbg} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 2'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_values: ready=%b busy=%b done=%b cmd=%0d sel=%0d/%0d/%0d wsel=%0d dbg=%h, need 1 0 0 0 0/0/0 0 0",
               req_ready, busy, done, cmd, sel_a, sel_b, sel_c, alu_wsel, state_dbg);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (dut_vec !== m_vec) begin
      failures++;
      $display("FAIL reset_release: got %h need %h", dut_vec, m_vec);
    end
  endtask

  task automatic test_alu_exec();
    logic [3:0] ec[5] = '{4'd4, 4'd1, 4'd2, 4'd6, 4'd0};
    logic       ed[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       er[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive_op(2'd1, 3'd1, 3'd2, 3'd3, 2'd1);
    checks++;
    if ({sel_a, sel_b, sel_c, alu_wsel} !== {3'd1, 3'd2, 3'd3, 2'd1}) begin
      failures++;
      $display("FAIL alu_selects: got %0d/%0d/%0d wsel=%0d need 1/2/3 wsel=1",
               sel_a, sel_b, sel_c, alu_wsel);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd !== ec[i] || done !== ed[i] || req_ready !== er[i]) begin
        failures++;
        $display("FAIL alu_seq[%0d]: cmd=%0d done=%b ready=%b need cmd=%0d done=%b ready=%b",
                 i, cmd, done, req_ready, ec[i], ed[i], er[i]);
      end
      checks++;
      if (dut_vec !== m_vec) begin
        failures++;
        $display("FAIL alu_model[%0d]: got %h need %h", i, dut_vec, m_vec);
      end
      step();
    end
  endtask

  task automatic test_write_c_zero();
    logic [3:0] ec[3] = '{4'd4, 4'd0, 4'd0};
    logic       ed[3] = '{1'b0, 1'b1, 1'b0};
    logic       er[3] = '{1'b0, 1'b0, 1'b1};
    logic       seen_lc = 1'b0;
    drive_op(2'd2, 3'd1, 3'd2, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      if (cmd == 4'd3) seen_lc = 1'b1;
      checks++;
      if (cmd !== ec[i] || done !== ed[i] || req_ready !== er[i]) begin
        failures++;
        $display("FAIL write_c0_seq[%0d]: cmd=%0d done=%b ready=%b need cmd=%0d done=%b ready=%b",
                 i, cmd, done, req_ready, ec[i], ed[i], er[i]);
      end
      checks++;
      if (dut_vec !== m_vec) begin
        failures++;
        $display("FAIL write_c0_model[%0d]: got %h need %h", i, dut_vec, m_vec);
      end
      step();
    end
    checks++;
    if (seen_lc !== 1'b0) begin
      failures++;
      $display("FAIL write_c0_no_latchc: saw COM_LATCHC=%b need 0", seen_lc);
    end
  endtask

  task automatic test_read_f_rfu();
    logic [3:0] ec[4] = '{4'd4, 4'd1, 4'd2, 4'd0};
    logic       ed[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive_op(2'd3, 3'd7, 3'd7, 3'd7, 2'd2);
    checks++;
    if (cmd !== 4'd5 || done !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL read_f_first: cmd=%0d done=%b ready=%b need cmd=5 done=1 ready=0", cmd, done, req_ready);
    end
    step();
    checks++;
    if (cmd !== 4'd0 || done !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL read_f_after: cmd=%0d done=%b ready=%b need cmd=0 done=0 ready=1", cmd, done, req_ready);
    end
    drive_op(2'd1, 3'd4, 3'd5, 3'd6, 2'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd !== ec[i] || done !== ed[i] || alu_wsel !== 2'd0) begin
        failures++;
        $display("FAIL alu_rfu_seq[%0d]: cmd=%0d done=%b wsel=%0d need cmd=%0d done=%b wsel=0",
                 i, cmd, done, alu_wsel, ec[i], ed[i]);
      end
      checks++;
      if (dut_vec !== m_vec) begin
        failures++;
        $display("FAIL alu_rfu_model[%0d]: got %h need %h", i, dut_vec, m_vec);
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [3:0] ec[8] = '{4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2, 4'd6, 4'd0};
    logic       st[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int         dones = 0;
    drive_op(2'd1, 3'd2, 3'd3, 3'd4, 2'd2);
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) dones++;
      checks++;
      if (cmd !== ec[i] || sel_a !== 3'd2) begin
        failures++;
        $display("FAIL stall_seq[%0d]: cmd=%0d sel_a=%0d need cmd=%0d sel_a=2", i, cmd, sel_a, ec[i]);
      end
      checks++;
      if (dut_vec !== m_vec) begin
        failures++;
        $display("FAIL stall_model[%0d]: got %h need %h", i, dut_vec, m_vec);
      end
      stall = st[i];
      step();
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL stall_done_count: got %0d need 1", dones);
    end
  endtask

  task automatic test_reset_mid_op();
    drive_op(2'd1, 3'd3, 3'd3, 3'd3, 2'd1);
    step(); step();
    checks++;
    if (cmd !== 4'd2) begin
      failures++;
      $display("FAIL rst_mid_pre: cmd=%0d need 2", cmd);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, done, cmd, sel_a, sel_b, sel_c, alu_wsel} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 2'd0}) begin
      failures++;
      $display("FAIL rst_mid_async: got %h need %h", dut_vec, 18'h20000);
    end
    step();
    rst_n = 1'b1;
    step();
    drive_op(2'd1, 3'd3, 3'd3, 3'd3, 2'd1);
    checks++;
    if (cmd !== 4'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_restart: cmd=%0d busy=%b need cmd=4 busy=1", cmd, busy);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

`ifdef SEQ_SKIP_LATCHSEL_EN
  task automatic test_skip_latchsel();
    logic [3:0] e1[3] = '{4'd4, 4'd1, 4'd2};
    logic [3:0] e2[2] = '{4'd1, 4'd2};
    drive_op(2'd0, 3'd5, 3'd6, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd !== e1[i]) begin
        failures++;
        $display("FAIL skip_first[%0d]: cmd=%0d need %0d", i, cmd, e1[i]);
      end
      step();
    end
    drive_op(2'd0, 3'd5, 3'd6, 3'd0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cmd !== e2[i] || done !== (i == 1)) begin
        failures++;
        $display("FAIL skip_second[%0d]: cmd=%0d done=%b need %0d", i, cmd, done, e2[i]);
      end
      step();
    end
    drive_op(2'd0, 3'd5, 3'd7, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd !== e1[i]) begin
        failures++;
        $display("FAIL skip_changed[%0d]: cmd=%0d need %0d", i, cmd, e1[i]);
      end
      step();
    end
  endtask
`endif

  task automatic test_random();
    int accepted = 0;
    int dones = 0;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (dut_vec !== m_vec) begin
        failures++;
        $display("FAIL random_model[%0d]: got %h need %h", i, dut_vec, m_vec);
      end
      if (done === 1'b1) dones++;
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 2'($urandom_range(0, 3));
      req_sel_a = 3'($urandom_range(0, 1));
      req_sel_b = 3'($urandom_range(0, 1));
      req_sel_c = 3'($urandom_range(0, 1));
      req_wsel  = 2'($urandom_range(0, 3));
      stall     = ($urandom_range(0, 3) == 0);
      if (req_valid && req_ready) accepted++;
      step();
    end
    req_valid = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != accepted) begin
      failures++;
      $display("FAIL random_done_count: got %0d need %0d", dones, accepted);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_exec();
    test_write_c_zero();
    test_read_f_rfu();
    test_stall();
    test_reset_mid_op();
`ifdef SEQ_SKIP_LATCHSEL_EN
    test_skip_latchsel();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
